// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The optional FETCH_PERF_CNT_EN feature is selected in fetch_unit.sv.
package fetch_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_ADDR_W   = 16;
    localparam int unsigned FETCH_DATA_W   = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: the branch target wins over the sequential PC+1.
// Wraps modulo 2^ADDR_W.
module pc_next_sel #(
    parameter int unsigned ADDR_W = 16
)(
    input  logic [ADDR_W-1:0] pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_nxt
);

    assign pc_nxt = br_taken ? br_target : (pc + ADDR_W'(1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-at-a-time memory read, IR handed to decode.
// Define FETCH_PERF_CNT_EN to build the saturating accepted-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [15:0]       fetch_count
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              ir_load, pc_load;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc        (pc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc_nxt    (pc_nxt)
    );

    // A redirect discards any ack arriving in the same cycle.
    assign ir_load   = (state == FETCH) && imem_ack && !br_taken;
    assign pc_load   = br_taken || ir_load;
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_valid  = 1'b0;
        case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = HOLD;
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (ir_ready) state_nxt = FETCH;
            end
            default: state_nxt = START;
        endcase
        if (br_taken) state_nxt = FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_load) pc <= pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_data <= '0;
            ir_pc   <= '0;
        end else if (ir_load) begin
            ir_data <= imem_rdata;
            ir_pc   <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= '0;
        else if (ir_valid && ir_ready) cnt <= sat_inc(cnt);
    end

    assign fetch_count = cnt;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr ^ 16'hC3C3 as the instruction word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        br_taken;
    logic [15:0] br_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic [15:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 16'hC3C3;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [15:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, "_vld"}, 32'(ir_valid), 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [15:0] data, input logic [15:0] pc);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_vld"}, 32'(ir_valid), 32'd1);
        chk({tag, "_data"}, 32'(ir_data), 32'(data));
        chk({tag, "_pc"}, 32'(ir_pc), 32'(pc));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0000);
        chk({tag, "_vld"}, 32'(ir_valid), 32'd0);
        chk({tag, "_data"}, 32'(ir_data), 32'h0000);
        chk({tag, "_pc"}, 32'(ir_pc), 32'h0000);
        chk({tag, "_cnt"}, 32'(fetch_count), 32'h0000);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b1; ir_ready = 1'b1;
        br_taken = 1'b0; br_target = 16'h0000;
        step(); step();
        chk_reset("rst");
        rst = 1'b0;

        // zero-wait memory, decode always ready
        step(); chk_fetch("f0", 16'h0000);
        step(); chk_hold("h0", 16'hC3C3, 16'h0000);
        step(); chk_fetch("f1", 16'h0001);
        step(); chk_hold("h1", 16'hC3C2, 16'h0001);
        step(); chk_fetch("f2", 16'h0002);
        step(); chk_hold("h2", 16'hC3C1, 16'h0002);

        // decode stalls four cycles
        ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk_hold("stall", 16'hC3C1, 16'h0002);
        end
        ir_ready = 1'b1;
        step(); chk_fetch("f3", 16'h0003);
        step(); chk_hold("h3", 16'hC3C0, 16'h0003);
        step(); chk_fetch("f4", 16'h0004);
        step(); chk_hold("h4", 16'hC3C7, 16'h0004);

        // memory acks three cycles late at 0005
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_fetch("wait5", 16'h0005);
        end
        imem_ack = 1'b1;
        step(); chk_hold("h5", 16'hC3C6, 16'h0005);
        chk("cnt5", 32'(fetch_count), CNT_EN ? 32'd5 : 32'd0);

        // branch coincident with ack: word discarded
        step(); chk_fetch("f6", 16'h0006);
        br_taken = 1'b1; br_target = 16'h1234;
        step(); br_taken = 1'b0;
        chk_fetch("br", 16'h1234);
        chk("br_keep_data", 32'(ir_data), 32'hC3C6);
        chk("br_keep_pc", 32'(ir_pc), 32'h0005);
        step(); chk_hold("h1234", 16'hD1F7, 16'h1234);

        // branch in HOLD with a coincident accept, then PC wrap at FFFF
        br_taken = 1'b1; br_target = 16'hFFFF;
        step(); br_taken = 1'b0;
        chk_fetch("brffff", 16'hFFFF);
        chk("cnt7", 32'(fetch_count), CNT_EN ? 32'd7 : 32'd0);
        step(); chk_hold("hffff", 16'h3C3C, 16'hFFFF);
        step(); chk_fetch("wrap", 16'h0000);
        chk("cnt8", 32'(fetch_count), CNT_EN ? 32'd8 : 32'd0);
        step(); chk_hold("h0w", 16'hC3C3, 16'h0000);

        // asynchronous reset in the middle of HOLD
        ir_ready = 1'b0;
        step(); chk_hold("h0s", 16'hC3C3, 16'h0000);
        #2 rst = 1'b1;
        #1 chk_reset("arst");
        step(); chk_reset("arst_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
